// File: rtl/uart_rx_ovs_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM state encoding,
// parity mode codes, vote sample offsets and the majority helper.
package uart_rx_ovs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Codes 00 and 11 both mean "no parity bit on the line".
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Samples are taken this many ticks before and after the mid-bit phase.
    localparam int VOTE_PRE  = 1;
    localparam int VOTE_POST = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider plus oversample phase counter. restart_i holds both counters
// at their start values so the first tick lands div_i clocks after release.
module uart_baud_tick #(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int PH_W       = $clog2(OVERSAMPLE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic [PH_W-1:0]  phase_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;

    assign tick_o  = !restart_i && (cnt_q == '0);
    assign phase_o = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart_i) begin
            cnt_d   = div_i - DIV_W'(1);
            phase_d = '0;
        end else if (tick_o) begin
            cnt_d   = div_i - DIV_W'(1);
            phase_d = (phase_q == PH_W'(OVERSAMPLE - 1)) ? '0 : phase_q + PH_W'(1);
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority vote per bit, runtime baud and
// parity, false-start rejection, error flags and a 1-deep valid/ready buffer.
module uart_rx_ovs
    import uart_rx_ovs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              break_det,
    output logic              overrun,
    output logic              rx_busy
);

    localparam int PH_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVERSAMPLE / 2 - VOTE_PRE);
    localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0] PH_S2   = PH_W'(OVERSAMPLE / 2 + VOTE_POST);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

    rx_state_e         state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        samp_q, samp_d;
    logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              stop_q, stop_d;
    logic              perr_w_q, perr_w_d, ferr_w_q, ferr_w_d;
    logic              need_high_q, need_high_d;
    logic              valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic              brk_q, brk_d, ovr_q, ovr_d;

    logic              rxs, idle, tick, vote, vote_en, bit_end, done, ferr_fin;
    logic [DIV_W-1:0]  baud_eff, tick_div;
    logic [PH_W-1:0]   phase;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign idle     = (state_q == ST_IDLE);
    assign baud_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
    // The divider reloads from the live setting while idle so the first tick
    // of a frame already uses the value being latched.
    assign tick_div = idle ? baud_eff : div_q;
    assign vote     = maj3(samp_q[0], samp_q[1], rxs);
    assign vote_en  = tick && (phase == PH_S2);
    assign bit_end  = tick && (phase == PH_LAST);

    uart_baud_tick #(
        .DIV_W      (DIV_W),
        .OVERSAMPLE (OVERSAMPLE),
        .PH_W       (PH_W)
    ) u_tick (
        .clk_i     (clk),
        .rst_i     (reset),
        .restart_i (idle),
        .div_i     (tick_div),
        .tick_o    (tick),
        .phase_o   (phase)
    );

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        mode_d      = mode_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        perr_w_d    = perr_w_q;
        ferr_w_d    = ferr_w_q;
        need_high_d = need_high_q && !rxs;
        data_d      = data_q;
        valid_d     = valid_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        brk_d       = brk_q;
        ovr_d       = 1'b0;
        done        = 1'b0;
        ferr_fin    = ferr_w_q;

        if (tick && (phase == PH_S0)) samp_d[0] = rxs;
        if (tick && (phase == PH_S1)) samp_d[1] = rxs;

        unique case (state_q)
            ST_IDLE: begin
                div_d    = baud_eff;
                mode_d   = parity_mode;
                bit_d    = '0;
                stop_d   = 1'b0;
                perr_w_d = 1'b0;
                ferr_w_d = 1'b0;
                if (!rxs && !need_high_q) state_d = ST_START;
            end
            ST_START: begin
                if (vote_en && vote)  state_d = ST_IDLE;
                else if (bit_end)     state_d = ST_DATA;
            end
            ST_DATA: begin
                if (vote_en) shift_d = {vote, shift_q[DATA_W-1:1]};
                if (bit_end) begin
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = (mode_q == PAR_EVEN || mode_q == PAR_ODD) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (vote_en) perr_w_d = ((^shift_q) ^ vote) != (mode_q == PAR_ODD);
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (vote_en) begin
                    ferr_fin = ferr_w_q | ~vote;
                    ferr_w_d = ferr_fin;
                    // Leave at the last stop vote: half a bit of margin to resync.
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        done        = 1'b1;
                        state_d     = ST_IDLE;
                        need_high_d = !rxs;
                    end
                end else if (bit_end) begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (valid_q && rx_ready) valid_d = 1'b0;
        if (done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                perr_d  = perr_w_q;
                ferr_d  = ferr_fin;
                brk_d   = (shift_q == '0) && ferr_fin;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sync_q      <= '1;
            div_q       <= '0;
            mode_q      <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            perr_w_q    <= 1'b0;
            ferr_w_q    <= 1'b0;
            need_high_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
            div_q       <= div_d;
            mode_q      <= mode_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            perr_w_q    <= perr_w_d;
            ferr_w_q    <= ferr_w_d;
            need_high_q <= need_high_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign break_det  = brk_q;
    assign overrun    = ovr_q;
    assign rx_busy    = !idle;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: drives whole frames on rx and checks every
// buffered frame against a frame-level model held in an expected queue.
module tb_uart_rx_ovs;

  localparam int DATA_W      = 8;
  localparam int STOP_BITS   = 1;
  localparam int OVERSAMPLE  = 16;
  localparam int DIV_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int W           = DATA_W + 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DIV_W-1:0]  baud_div = 16'd4;
  logic [1:0]        parity_mode = 2'b00;
  logic              rx = 1'b1;
  logic              rx_ready = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, parity_err, frame_err, break_det, overrun, rx_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_acc = '0;
  int ovr_cnt = 0;
  int exp_ovr = 0;
  bit busy_seen = 1'b0;
  int lat;

  uart_rx_ovs #(
    .DATA_W(DATA_W), .STOP_BITS(STOP_BITS), .OVERSAMPLE(OVERSAMPLE),
    .DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
    .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
    .overrun(overrun), .rx_busy(rx_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // frame model: {break, frame_err, parity_err, data}
  function automatic logic [W-1:0] exp_word(input logic [DATA_W-1:0] d, input logic [1:0] mode,
                                            input logic pb, input logic sv);
    int ones;
    logic pe, fe, be;
    ones = $countones(d) + int'(pb);
    pe = 1'b0;
    if (mode == 2'b01) pe = (ones % 2) != 0;
    else if (mode == 2'b10) pe = (ones % 2) != 1;
    fe = !sv;
    be = fe && (d == '0);
    return {be, fe, pe, d};
  endfunction

  // clocks from start-bit edge to rx_valid: sync + restart, mid-bit vote of last stop bit, +1
  function automatic int exp_lat(input int div, input bit hp);
    int d;
    d = (div == 0) ? 1 : div;
    return SYNC_STAGES + 1 + d * (OVERSAMPLE / 2 + 2) + d * OVERSAMPLE * (DATA_W + int'(hp) + STOP_BITS);
  endfunction

  // driver tasks
  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input bit hp, input logic pb,
                            input logic sv, input int bclk, input int gbit);
    logic [15:0] seq;
    int n;
    seq = '1;
    seq[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) seq[1+i] = d[i];
    n = 1 + DATA_W;
    if (hp) begin seq[n] = pb; n++; end
    for (int i = 0; i < STOP_BITS; i++) begin seq[n] = sv; n++; end
    for (int b = 0; b < n; b++)
      for (int c = 0; c < bclk; c++) begin
        @(negedge clk);
        rx = (b == gbit && c == bclk / 2) ? ~seq[b] : seq[b];
      end
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_and_time(input logic [DATA_W-1:0] d, input bit hp, input logic pb,
                               input int bclk, output int lt);
    int l;
    l = -1;
    fork
      send_frame(d, hp, pb, 1'b1, bclk, -1);
      begin
        @(negedge clk);
        for (int c = 1; c <= 4000; c++) begin
          @(negedge clk);
          if (rx_valid) begin l = c; break; end
        end
      end
    join
    lt = l;
  endtask

  // scoreboard compare: every cycle the buffer is valid
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (rx_busy) busy_seen = 1'b1;
        if (overrun) ovr_cnt++;
        if (rx_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0h, expected no frame",
                     {break_det, frame_err, parity_err, rx_data});
          end else begin
            check("frame", {break_det, frame_err, parity_err, rx_data}, exp_q[0]);
            if (rx_ready) begin
              last_acc = {break_det, frame_err, parity_err, rx_data};
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    // reset state
    idle_clks(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_flags", {parity_err, frame_err, break_det, overrun, rx_busy}, 0);
    reset = 1'b0;
    idle_clks(20);

    // 1: 8N1 0xA5, latency to rx_valid
    rx_ready = 1'b1;
    exp_q.push_back(exp_word(8'hA5, 2'b00, 1'b0, 1'b1));
    send_and_time(8'hA5, 1'b0, 1'b0, 64, lat);
    check("t1_latency", lat, 619);
    check("t1_latency_model", lat, exp_lat(4, 1'b0));
    idle_clks(64);
    check("t1_frame", last_acc, 11'h0A5);

    // 2: parity even/odd with both parity bit values
    for (int m = 1; m <= 2; m++) begin
      for (int p = 0; p <= 1; p++) begin
        parity_mode = 2'(m);
        exp_q.push_back(exp_word(8'h07, 2'(m), 1'(p), 1'b1));
        send_frame(8'h07, 1'b1, 1'(p), 1'b1, 64, -1);
        idle_clks(64);
        check("t2_parity_err", last_acc[DATA_W], (m == 1) ? (p == 0) : (p == 1));
      end
    end
    parity_mode = 2'b00;

    // 3: false start and mid-bit glitch
    busy_seen = 1'b0;
    @(negedge clk); rx = 1'b0;
    idle_clks(20);
    rx = 1'b1;
    idle_clks(200);
    check("t3_busy_pulsed", busy_seen, 1);
    check("t3_busy_back", rx_busy, 0);
    check("t3_no_frame", exp_q.size(), 0);
    exp_q.push_back(exp_word(8'h5A, 2'b00, 1'b0, 1'b1));
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 64, 3);
    idle_clks(64);
    check("t3_glitch_frame", last_acc, 11'h05A);

    // 4: overrun, then accept on the completion clock
    rx_ready = 1'b0;
    exp_q.push_back(exp_word(8'h11, 2'b00, 1'b0, 1'b1));
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 64, -1);
    idle_clks(64);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 64, -1);
    exp_ovr++;
    idle_clks(64);
    check("t4_held_data", rx_data, 8'h11);
    check("t4_overrun_count", ovr_cnt, exp_ovr);
    rx_ready = 1'b1;
    idle_clks(4);
    check("t4_first_kept", last_acc, 11'h011);
    rx_ready = 1'b0;
    exp_q.push_back(exp_word(8'h33, 2'b00, 1'b0, 1'b1));
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 64, -1);
    idle_clks(64);
    exp_q.push_back(exp_word(8'h44, 2'b00, 1'b0, 1'b1));
    fork
      send_frame(8'h44, 1'b0, 1'b0, 1'b1, 64, -1);
      begin
        @(negedge clk);
        repeat (exp_lat(4, 1'b0) - 1) @(negedge clk);
        rx_ready = 1'b1;
      end
    join
    idle_clks(64);
    check("t4_same_cycle_load", last_acc, 11'h044);
    check("t4_no_new_overrun", ovr_cnt, exp_ovr);
    check("t4_drained", exp_q.size(), 0);

    // 5: break held for 12 bit times
    exp_q.push_back(exp_word(8'h00, 2'b00, 1'b0, 1'b0));
    @(negedge clk); rx = 1'b0;
    idle_clks(11 * 64 + 32);
    check("t5_idle_while_low", rx_busy, 0);
    check("t5_one_frame", exp_q.size(), 0);
    check("t5_break_frame", last_acc, 11'h600);
    idle_clks(32);
    rx = 1'b1;
    idle_clks(200);
    check("t5_no_second", exp_q.size(), 0);
    check("t5_busy_after", rx_busy, 0);

    // 6: reset mid-DATA, then clean frame; baud_div 0 with mid-frame change
    @(negedge clk); rx = 1'b0;
    idle_clks(64); rx = 1'b1;
    idle_clks(64); rx = 1'b0;
    idle_clks(96);
    check("t6_busy_in_frame", rx_busy, 1);
    rx = 1'b1;
    reset = 1'b1;
    #1;
    check("t6_rst_data", rx_data, 0);
    check("t6_rst_outs", {rx_valid, parity_err, frame_err, break_det, overrun, rx_busy}, 0);
    idle_clks(3);
    reset = 1'b0;
    idle_clks(12 * 64);
    check("t6_no_frame", exp_q.size(), 0);
    exp_q.push_back(exp_word(8'h3C, 2'b00, 1'b0, 1'b1));
    send_and_time(8'h3C, 1'b0, 1'b0, 64, lat);
    check("t6_latency", lat, exp_lat(4, 1'b0));
    idle_clks(64);
    check("t6_clean_frame", last_acc, 11'h03C);
    baud_div = 16'd0;
    exp_q.push_back(exp_word(8'h96, 2'b00, 1'b0, 1'b1));
    fork
      send_and_time(8'h96, 1'b0, 1'b0, 16, lat);
      begin
        idle_clks(40);
        baud_div = 16'd7;
      end
    join
    check("t6_div0_latency", lat, 157);
    idle_clks(64);
    check("t6_div0_frame", last_acc, 11'h096);
    check("final_drained", exp_q.size(), 0);
    check("final_overrun", ovr_cnt, exp_ovr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
